prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Write-side counterpart to the fetch/decode path. Accepts symbolic instruction fields (opcode, argument) over a valid/ready stream from a host or test bench.
- Packs each field pair into the 9-bit instruction word and writes the words to instruction memory at consecutive addresses.
- Stops at the program terminator (func/done), reports word count and XOR checksum, and flags overflow.

Parameters:
- ADDR_W, 8, instruction memory address width
- DEPTH, 256, number of writable instruction slots; must be ≤ 2**ADDR_W and ≥ 2

Ports:
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins a load session (honoured only in IDLE, DONE or ERR)
- abort  in  1  return to IDLE from any state; pending word discarded
- base_addr  in  ADDR_W  first write address, sampled on start
- in_valid  in  1  field pair valid
- in_op  in  5  opcode field, instr[8:4]
- in_arg  in  4  argument field (register/math/function/immediate), instr[3:0]
- in_ready  out  1  loader can accept a field pair this cycle
- imem_we  out  1  instruction memory write enable
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  9  packed instruction {in_op, in_arg}
- busy  out  1  state is LOAD or WRITE
- done  out  1  level; terminator written, held until start/abort
- err  out  1  level; overflow, held until start/abort
- word_count  out  ADDR_W+1  words written this session
- checksum  out  9  XOR of all words written this session

Behaviour:
- Reset (rstn=0 at posedge): state IDLE; in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, word_count=0, checksum=0. Reset mid-session abandons the session; already-written memory contents are untouched.
- Encoding: word = {op[4:0], arg[3:0]}. No field validation; every pair is written verbatim. Terminator is op=5'd31 (func) with arg=4'd15 (done), i.e. word 9'h1FF.
- States: IDLE, LOAD, WRITE, DONE, ERR.
- IDLE/DONE/ERR + start:
  - go to LOAD; wr_ptr<=base_addr.
  - word_count, checksum, done, err all cleared.
  - start in LOAD/WRITE is ignored.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready, latch the word into imem_wdata and go to WRITE.
- WRITE (exactly one cycle):
  - imem_we=1, imem_addr=wr_ptr, in_ready=0.
  - At the posedge: word_count+=1, checksum^=word, wr_ptr+=1, with wraparound modulo 2**ADDR_W.
  - Next state:
    - word is 9'h1FF → DONE (terminator takes priority over overflow).
    - else new word_count == DEPTH → ERR.
    - else → LOAD.
  - Throughput: one word per 2 cycles; accept-to-write latency is 1 cycle.
- DONE: done=1, in_ready=0, outputs frozen.
- ERR: err=1, in_ready=0, outputs frozen. The DEPTH-th word is written before ERR is entered.
- abort:
  - Overrides everything except rstn.
  - Next state IDLE, imem_we=0 on the following cycle; no write of the pending word.
  - word_count and checksum keep their values; done and err are cleared.
  - abort and start in the same cycle → abort wins.
- imem_we is only ever asserted in WRITE. imem_addr/imem_wdata hold their last values otherwise.
- busy=1 in LOAD and WRITE.

Test Plan:
- Reset then start with base_addr=8'h10; send {lith,4'h3},{movc,r},{func,done} (9'h053,9'h040,9'h1FF) → writes at 0x10,0x11,0x12; done=1; word_count=3; checksum=9'h1EC; exactly 3 imem_we pulses.
- in_valid held high continuously → in_ready toggles 1,0,1,0; writes one cycle after each accept; no pair lost or duplicated.
- DEPTH=4, base 0, five non-terminator words offered → 4 writes at 0..3, err=1 after the 4th, in_ready=0, 5th never accepted. With the 4th word = 9'h1FF instead → done=1, err=0.
- base_addr=8'hFF, two words → writes at 0xFF then 0x00.
- abort asserted in the WRITE cycle of word 2 → word 2 is written (imem_we already high that cycle); state IDLE next; done=0; further in_valid ignored. abort in the LOAD accept cycle → no write.
- rstn low during LOAD → all outputs return to reset values next cycle; start afterwards begins a clean session with count 0.

Source files
------------

// File: rtl/prog_loader.sv
// Program loader: accepts {opcode, argument} field pairs over a valid/ready stream,
// packs them into 9-bit instruction words and writes them to consecutive imem addresses.
module prog_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    input  logic [4:0]        in_op,
    input  logic [3:0]        in_arg,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [8:0]        imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count,
    output logic [8:0]        checksum,
    output logic [2:0]        dbg_state
);

    // Handshake: a field pair transfers on a rising edge where in_valid && in_ready.
    // in_ready is high only in LOAD, so at most one pair is in flight at any time.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [8:0]      TERM_WORD = 9'h1FF;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   cnt_inc;
    logic              idle_like;
    logic              start_ok;
    logic              accept;

    always_comb begin
        idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
        start_ok  = idle_like && start && !abort;
        accept    = (state == S_LOAD) && in_valid && !abort;
        cnt_inc   = word_count + (ADDR_W+1)'(1);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (in_valid) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                // The terminator wins even if it is also the DEPTH-th word.
                if (imem_wdata == TERM_WORD)  state_nxt = S_DONE;
                else if (cnt_inc == DEPTH_CNT) state_nxt = S_ERR;
                else                          state_nxt = S_LOAD;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_comb begin
        in_ready  = (state == S_LOAD);
        imem_we   = (state == S_WRITE);
        busy      = (state == S_LOAD) || (state == S_WRITE);
        done      = (state == S_DONE);
        err       = (state == S_ERR);
        dbg_state = state;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            word_count <= '0;
            checksum   <= '0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                wr_ptr     <= base_addr;
                word_count <= '0;
                checksum   <= '0;
            end
            // Address and data are captured together so they stay stable through WRITE
            // and keep their last values afterwards.
            if (accept) begin
                imem_wdata <= {in_op, in_arg};
                imem_addr  <= wr_ptr;
            end
            if (state == S_WRITE) begin
                word_count <= cnt_inc;
                checksum   <= checksum ^ imem_wdata;
                wr_ptr     <= wr_ptr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a DEPTH=256 instance for the main flow and a DEPTH=4
// instance sharing the same stimulus for the overflow/terminator boundary cases.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] base_addr = '0;
    logic       in_valid = 1'b0;
    logic [4:0] in_op = '0;
    logic [3:0] in_arg = '0;

    logic       in_ready, imem_we, busy, done, err;
    logic [7:0] imem_addr;
    logic [8:0] imem_wdata, checksum;
    logic [8:0] word_count;
    logic [2:0] dbg_state;

    logic       in_ready4, imem_we4, busy4, done4, err4;
    logic [7:0] imem_addr4;
    logic [8:0] imem_wdata4, checksum4;
    logic [8:0] word_count4;
    logic [2:0] dbg_state4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(8), .DEPTH(256)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .base_addr(base_addr),
        .in_valid(in_valid), .in_op(in_op), .in_arg(in_arg), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy),
        .done(done), .err(err), .word_count(word_count), .checksum(checksum),
        .dbg_state(dbg_state)
    );

    prog_loader #(.ADDR_W(8), .DEPTH(4)) dut4 (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .base_addr(base_addr),
        .in_valid(in_valid), .in_op(in_op), .in_arg(in_arg), .in_ready(in_ready4),
        .imem_we(imem_we4), .imem_addr(imem_addr4), .imem_wdata(imem_wdata4), .busy(busy4),
        .done(done4), .err(err4), .word_count(word_count4), .checksum(checksum4),
        .dbg_state(dbg_state4)
    );

    // Write monitors: record {addr, data} of every write while enabled.
    logic        mon_main = 1'b1;
    logic        mon4 = 1'b0;
    logic [16:0] act_q[$];
    logic [16:0] act4_q[$];
    int          we_cnt = 0;

    always @(posedge clk) begin
        if (imem_we) we_cnt <= we_cnt + 1;
        if (mon_main && imem_we) act_q.push_back({imem_addr, imem_wdata});
        if (mon4 && imem_we4) act4_q.push_back({imem_addr4, imem_wdata4});
    end

    // Scoreboard state, owned by the initial block.
    logic [16:0] exp_q[$];
    logic [16:0] exp4_q[$];
    int          exp_total = 0;
    int          exp4_total = 0;
    int          rd = 0;
    int          rd4 = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_wr(input bit use4, input logic [7:0] a, input logic [8:0] w);
        if (use4) begin
            exp4_q.push_back({a, w});
            exp4_total++;
        end else begin
            exp_q.push_back({a, w});
            exp_total++;
        end
    endtask

    // Compare recorded writes against the expected queue, then the write counts.
    task automatic drain(input string tag);
        logic [16:0] e;
        while (rd < act_q.size() && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_wr"}, 32'(act_q[rd]), 32'(e));
            rd++;
        end
        while (rd4 < act4_q.size() && exp4_q.size() > 0) begin
            e = exp4_q.pop_front();
            chk({tag, "_wr4"}, 32'(act4_q[rd4]), 32'(e));
            rd4++;
        end
        chk({tag, "_nwr"}, act_q.size(), exp_total);
        chk({tag, "_nwr4"}, act4_q.size(), exp4_total);
    endtask

    task automatic send(input bit use4, input logic [8:0] w, output bit acc);
        in_valid = 1'b1;
        {in_op, in_arg} = w;
        acc = 1'b0;
        for (int i = 0; i < 8 && !acc; i++) begin
            if (use4 ? in_ready4 : in_ready) acc = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] base);
        base_addr = base;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic wait_flag(input bit use4, input bit want_err);
        for (int i = 0; i < 20; i++) begin
            if (use4 ? (want_err ? err4 : done4) : (want_err ? err : done)) break;
            tick();
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rdy"}, in_ready, 0);
        chk({tag, "_we"}, imem_we, 0);
        chk({tag, "_addr"}, imem_addr, 0);
        chk({tag, "_wdata"}, imem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_cnt"}, word_count, 0);
        chk({tag, "_csum"}, checksum, 0);
    endtask

    initial begin
        bit acc;
        int we_base;
        logic [8:0] words[3];
        int widx;

        // Reset
        rstn = 1'b0;
        tick();
        tick();
        chk_reset("rst");
        rstn = 1'b1;
        tick();

        // Basic program: lith 3, movc r, func done
        we_base = we_cnt;
        do_start(8'h10);
        chk("t1_busy", busy, 1);
        send(1'b0, 9'h053, acc); chk("t1_acc0", acc, 1);
        send(1'b0, 9'h040, acc); chk("t1_acc1", acc, 1);
        send(1'b0, 9'h1FF, acc); chk("t1_acc2", acc, 1);
        exp_wr(1'b0, 8'h10, 9'h053);
        exp_wr(1'b0, 8'h11, 9'h040);
        exp_wr(1'b0, 8'h12, 9'h1FF);
        wait_flag(1'b0, 1'b0);
        chk("t1_done", done, 1);
        chk("t1_err", err, 0);
        chk("t1_cnt", word_count, 3);
        chk("t1_csum", checksum, 9'h1EC);
        chk("t1_rdy", in_ready, 0);
        chk("t1_busy_end", busy, 0);
        chk("t1_addr_hold", imem_addr, 8'h12);
        tick();
        chk("t1_pulses", we_cnt - we_base, 3);
        drain("t1");

        // Continuous in_valid: ready toggles, one write per two cycles
        do_abort();
        do_start(8'h20);
        words[0] = 9'h0A1; words[1] = 9'h0B2; words[2] = 9'h0C3;
        widx = 0;
        in_valid = 1'b1;
        {in_op, in_arg} = words[0];
        for (int i = 0; i < 6; i++) begin
            bit r;
            r = in_ready;
            chk("t2_rdy", r, (i % 2 == 0) ? 1 : 0);
            tick();
            if (r) begin
                widx++;
                if (widx < 3) {in_op, in_arg} = words[widx];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        exp_wr(1'b0, 8'h20, 9'h0A1);
        exp_wr(1'b0, 8'h21, 9'h0B2);
        exp_wr(1'b0, 8'h22, 9'h0C3);
        tick();
        chk("t2_cnt", word_count, 3);
        chk("t2_csum", checksum, 9'h0A1 ^ 9'h0B2 ^ 9'h0C3);
        do_abort();
        chk("t2_cnt_abort", word_count, 3);
        chk("t2_busy_abort", busy, 0);
        drain("t2");

        // DEPTH=4 overflow, then DEPTH-th word as terminator
        mon_main = 1'b0;
        mon4 = 1'b1;
        do_start(8'h00);
        send(1'b1, 9'h001, acc); chk("t3_acc1", acc, 1);
        send(1'b1, 9'h002, acc); chk("t3_acc2", acc, 1);
        send(1'b1, 9'h003, acc); chk("t3_acc3", acc, 1);
        send(1'b1, 9'h004, acc); chk("t3_acc4", acc, 1);
        send(1'b1, 9'h005, acc); chk("t3_acc5", acc, 0);
        for (int i = 0; i < 4; i++) exp_wr(1'b1, 8'(i), 9'(i + 1));
        chk("t3_err", err4, 1);
        chk("t3_done", done4, 0);
        chk("t3_rdy", in_ready4, 0);
        chk("t3_cnt", word_count4, 4);
        chk("t3_csum", checksum4, 9'h004);
        do_abort();
        chk("t3_err_clr", err4, 0);
        do_start(8'h00);
        chk("t3b_cnt0", word_count4, 0);
        send(1'b1, 9'h001, acc);
        send(1'b1, 9'h002, acc);
        send(1'b1, 9'h003, acc);
        send(1'b1, 9'h1FF, acc); chk("t3b_acc4", acc, 1);
        for (int i = 0; i < 3; i++) exp_wr(1'b1, 8'(i), 9'(i + 1));
        exp_wr(1'b1, 8'h03, 9'h1FF);
        tick();
        chk("t3b_done", done4, 1);
        chk("t3b_err", err4, 0);
        chk("t3b_cnt", word_count4, 4);
        do_abort();
        mon4 = 1'b0;
        mon_main = 1'b1;
        drain("t3");

        // Address wraparound
        do_start(8'hFF);
        send(1'b0, 9'h0AA, acc);
        send(1'b0, 9'h0BB, acc);
        exp_wr(1'b0, 8'hFF, 9'h0AA);
        exp_wr(1'b0, 8'h00, 9'h0BB);
        tick();
        chk("t4_cnt", word_count, 2);
        do_abort();
        drain("t4");

        // Abort in the WRITE cycle of word 2: that write still lands
        do_start(8'h30);
        send(1'b0, 9'h011, acc);
        send(1'b0, 9'h022, acc);
        chk("t5_we_at_abort", imem_we, 1);
        exp_wr(1'b0, 8'h30, 9'h011);
        exp_wr(1'b0, 8'h31, 9'h022);
        do_abort();
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_rdy", in_ready, 0);
        in_valid = 1'b1;
        {in_op, in_arg} = 9'h077;
        tick(); tick(); tick();
        in_valid = 1'b0;
        chk("t5_idle_rdy", in_ready, 0);
        drain("t5");

        // Abort in the LOAD accept cycle: no write
        do_start(8'h40);
        in_valid = 1'b1;
        {in_op, in_arg} = 9'h066;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        chk("t6_we", imem_we, 0);
        chk("t6_busy", busy, 0);
        tick(); tick();
        drain("t6");

        // Reset during LOAD, then a clean session
        do_start(8'h50);
        send(1'b0, 9'h033, acc);
        exp_wr(1'b0, 8'h50, 9'h033);
        tick();
        chk("t7_in_load", in_ready, 1);
        rstn = 1'b0;
        tick();
        chk_reset("t7rst");
        rstn = 1'b1;
        tick();
        do_start(8'h60);
        chk("t7_cnt0", word_count, 0);
        chk("t7_csum0", checksum, 0);
        send(1'b0, 9'h1FF, acc);
        exp_wr(1'b0, 8'h60, 9'h1FF);
        wait_flag(1'b0, 1'b0);
        chk("t7_done", done, 1);
        chk("t7_cnt", word_count, 1);
        chk("t7_csum", checksum, 9'h1FF);
        tick();
        drain("t7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time exceeded limit");
        $fatal(1);
    end

endmodule
